// File: rtl/mig_app_responder.sv
// mig_app_responder: on-chip RAM responder for the MIG 7-series app_* UI.
// Command/data FIFOs feed an in-order executor; reads return through a fixed pipe.
module mig_app_responder #(
  parameter int ADDR_WIDTH   = 29,
  parameter int DATA_WIDTH   = 256,
  parameter int MASK_WIDTH   = 32,
  parameter int DEPTH_LOG2   = 6,
  parameter int FIFO_DEPTH   = 4,
  parameter int RD_LATENCY   = 4,
  parameter int CALIB_CYCLES = 64,
  parameter int STALL_PERIOD = 0
) (
  input  logic                  ui_clk,
  input  logic                  sys_rst,
  output logic                  init_calib_complete,
  input  logic [ADDR_WIDTH-1:0] app_addr,
  input  logic [2:0]            app_cmd,
  input  logic                  app_en,
  output logic                  app_rdy,
  input  logic [DATA_WIDTH-1:0] app_wdf_data,
  input  logic                  app_wdf_wren,
  input  logic                  app_wdf_end,
  input  logic [MASK_WIDTH-1:0] app_wdf_mask,
  output logic                  app_wdf_rdy,
  output logic [DATA_WIDTH-1:0] app_rd_data,
  output logic                  app_rd_data_valid,
  output logic                  app_rd_data_end,
  input  logic                  app_ref_req,
  input  logic                  app_zq_req,
  output logic                  app_ref_ack,
  output logic                  app_zq_ack,
  output logic                  proto_err
);

  localparam int WORDS = 2 ** DEPTH_LOG2;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(CALIB_CYCLES + 1);
  localparam int SP    = (STALL_PERIOD > 0) ? STALL_PERIOD : 1;
  localparam int SW    = $clog2(SP + 1);
  localparam int IL    = 3;
  localparam int IH    = 3 + DEPTH_LOG2 - 1;

  localparam logic [CW-1:0] CAL_LAST = CW'(CALIB_CYCLES - 1);
  localparam logic [CW-1:0] CAL_WRDS = CW'(WORDS);
  localparam logic [SW-1:0] STL_LAST = SW'(SP - 1);

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef struct packed {
    logic [2:0]            cmd;
    logic [DEPTH_LOG2-1:0] idx;
  } cmd_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [MASK_WIDTH-1:0] mask;
  } wdf_t;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  logic                  r_calib;
  logic [CW-1:0]         r_cal_cnt;
  logic [SW-1:0]         r_stall_cnt;
  cmd_t                  r_cq [FIFO_DEPTH];
  logic [PW:0]           r_cwp;
  logic [PW:0]           r_crp;
  wdf_t                  r_dq [FIFO_DEPTH];
  logic [PW:0]           r_dwp;
  logic [PW:0]           r_drp;
  logic [RD_LATENCY-1:0] r_pv;
  logic [DATA_WIDTH-1:0] r_pd [RD_LATENCY];
  logic                  r_ref_ack;
  logic                  r_zq_ack;
  logic                  r_perr;
  logic [DATA_WIDTH-1:0] r_mem [WORDS];

  logic                  w_c_empty;
  logic                  w_c_full;
  logic                  w_d_empty;
  logic                  w_d_full;
  logic                  w_stall;
  logic                  w_c_push;
  logic                  w_d_push;
  logic                  w_c_pop;
  logic                  w_d_pop;
  cmd_t                  w_head;
  wdf_t                  w_dhead;
  state_t                w_state;
  logic                  w_ex_rd;
  logic                  w_ex_wr;
  logic                  w_ex_drop;
  logic                  w_clr;
  logic [DEPTH_LOG2-1:0] w_clr_idx;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_unused;

  assign w_unused = ^{app_addr[IL-1:0], app_addr[ADDR_WIDTH-1:IH+1]};

  assign w_c_empty = (r_cwp == r_crp);
  assign w_c_full  = (r_cwp[PW] != r_crp[PW]) &&
                     (r_cwp[PW-1:0] == r_crp[PW-1:0]);
  assign w_d_empty = (r_dwp == r_drp);
  assign w_d_full  = (r_dwp[PW] != r_drp[PW]) &&
                     (r_dwp[PW-1:0] == r_drp[PW-1:0]);

  assign w_stall = (STALL_PERIOD > 0) && (r_stall_cnt == STL_LAST);

  assign app_rdy     = r_calib & ~w_c_full & ~w_stall;
  assign app_wdf_rdy = r_calib & ~w_d_full;

  assign w_c_push = app_en & app_rdy;
  assign w_d_push = app_wdf_wren & app_wdf_rdy;

  assign w_head    = r_cq[r_crp[PW-1:0]];
  assign w_dhead   = r_dq[r_drp[PW-1:0]];
  assign w_state   = w_c_empty ? IDLE : EXEC;
  assign w_rd_word = r_mem[w_head.idx];

  assign w_clr     = ~r_calib && (r_cal_cnt < CAL_WRDS);
  assign w_clr_idx = r_cal_cnt[DEPTH_LOG2-1:0];

  // Executor: one head command per cycle, a write waits for its data beat.
  always_comb begin
    w_ex_rd   = 1'b0;
    w_ex_wr   = 1'b0;
    w_ex_drop = 1'b0;
    unique case (w_state)
      IDLE: w_ex_rd = 1'b0;
      EXEC: begin
        unique case (1'b1)
          (w_head.cmd == CMD_RD): w_ex_rd = 1'b1;
          (w_head.cmd == CMD_WR): w_ex_wr = ~w_d_empty;
          default:                w_ex_drop = 1'b1;
        endcase
      end
    endcase
  end

  assign w_c_pop = w_ex_rd | w_ex_wr | w_ex_drop;
  assign w_d_pop = w_ex_wr;

  // Calibration: count up once after reset, then hold complete.
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_calib   <= 1'b0;
      r_cal_cnt <= '0;
    end else if (!r_calib) begin
      if (r_cal_cnt == CAL_LAST) r_calib <= 1'b1;
      else r_cal_cnt <= r_cal_cnt + 1'b1;
    end
  end

  // Backpressure phase counter, wraps every STALL_PERIOD cycles.
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_stall_cnt <= '0;
    end else if (r_stall_cnt == STL_LAST) begin
      r_stall_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // FIFO pointers for the command and write-data channels.
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_cwp <= '0;
      r_crp <= '0;
      r_dwp <= '0;
      r_drp <= '0;
    end else begin
      if (w_c_push) r_cwp <= r_cwp + 1'b1;
      if (w_c_pop)  r_crp <= r_crp + 1'b1;
      if (w_d_push) r_dwp <= r_dwp + 1'b1;
      if (w_d_pop)  r_drp <= r_drp + 1'b1;
    end
  end

  // FIFO storage; only the pointers need reset.
  always_ff @(posedge ui_clk) begin
    if (w_c_push) begin
      r_cq[r_cwp[PW-1:0]] <= '{cmd: app_cmd, idx: app_addr[IH:IL]};
    end
    if (w_d_push) begin
      r_dq[r_dwp[PW-1:0]] <= '{data: app_wdf_data, mask: app_wdf_mask};
    end
  end

  // Burst RAM: clear sweep during calibration, byte writes afterwards.
  always_ff @(posedge ui_clk) begin
    if (w_clr) begin
      r_mem[w_clr_idx] <= '0;
    end else if (w_ex_wr) begin
      for (int b = 0; b < MASK_WIDTH; b++) begin
        if (!w_dhead.mask[b]) begin
          r_mem[w_head.idx][b*8 +: 8] <= w_dhead.data[b*8 +: 8];
        end
      end
    end
  end

  // Read return pipe; data is zero whenever its valid bit is clear.
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_pv <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_pd[i] <= '0;
    end else begin
      r_pv[0] <= w_ex_rd;
      r_pd[0] <= w_ex_rd ? w_rd_word : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pd[i] <= r_pd[i-1];
      end
    end
  end

  // Maintenance acks and the sticky protocol error flag.
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_ref_ack <= 1'b0;
      r_zq_ack  <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_ref_ack <= app_ref_req;
      r_zq_ack  <= app_zq_req;
      if ((app_wdf_wren != app_wdf_end) ||
          (~r_calib && (app_en || app_wdf_wren))) begin
        r_perr <= 1'b1;
      end
    end
  end

  assign init_calib_complete = r_calib;
  assign app_rd_data         = r_pd[RD_LATENCY-1];
  assign app_rd_data_valid   = r_pv[RD_LATENCY-1];
  assign app_rd_data_end     = r_pv[RD_LATENCY-1];
  assign app_ref_ack         = r_ref_ack;
  assign app_zq_ack          = r_zq_ack;
  assign proto_err           = r_perr;

endmodule

// File: tb/tb_mig_app_responder.sv
// tb_mig_app_responder: scoreboard bench for the app_* UI responder.
// Reference memory model predicts read bursts; a monitor checks returns.
module tb_mig_app_responder;

  localparam int AW   = 29;
  localparam int DW   = 256;
  localparam int MW   = 32;
  localparam int DL   = 6;
  localparam int WRDS = 64;
  localparam int RDL  = 4;
  localparam int CAL  = 64;
  localparam int SPER = 3;

  logic          ui_clk = 1'b0;
  logic          sys_rst;
  logic          init_calib_complete;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en;
  logic          app_rdy;
  logic [DW-1:0] app_wdf_data;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic [MW-1:0] app_wdf_mask;
  logic          app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic          app_rd_data_end;
  logic          app_ref_req;
  logic          app_zq_req;
  logic          app_ref_ack;
  logic          app_zq_ack;
  logic          proto_err;

  always #5 ui_clk = ~ui_clk;

  mig_app_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
    .DEPTH_LOG2(DL), .FIFO_DEPTH(4), .RD_LATENCY(RDL),
    .CALIB_CYCLES(CAL), .STALL_PERIOD(SPER)
  ) dut (
    .ui_clk(ui_clk), .sys_rst(sys_rst),
    .init_calib_complete(init_calib_complete),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_rdy(app_rdy), .app_wdf_data(app_wdf_data),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end), .app_ref_req(app_ref_req),
    .app_zq_req(app_zq_req), .app_ref_ack(app_ref_ack),
    .app_zq_ack(app_zq_ack), .proto_err(proto_err)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_rx = 0;
  int last_rx_cyc = 0;
  int last_acc_cyc = 0;
  logic [DW-1:0] last_rx;
  bit log_rdy = 0;
  bit rdy_log[$];

  logic [2:0]    m_cq_c[$];
  int            m_cq_i[$];
  logic [DW-1:0] m_dq_d[$];
  logic [MW-1:0] m_dq_m[$];
  logic [DW-1:0] expq[$];
  logic [DW-1:0] ref_mem[WRDS];

  always @(posedge ui_clk) cyc++;

  function automatic void chk(string nm, logic [DW-1:0] act,
                              logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Apply queued commands in order; a write needs the next data beat.
  function automatic void model_advance();
    logic [DW-1:0] keep;
    logic [DW-1:0] d;
    logic [MW-1:0] m;
    int ix;
    while (m_cq_c.size() > 0) begin
      ix = m_cq_i[0];
      if (m_cq_c[0] == 3'b001) begin
        expq.push_back(ref_mem[ix]);
      end else if (m_cq_c[0] == 3'b000) begin
        if (m_dq_d.size() == 0) break;
        d = m_dq_d.pop_front();
        m = m_dq_m.pop_front();
        for (int b = 0; b < MW; b++) keep[8*b +: 8] = m[b] ? 8'hFF : 8'h00;
        ref_mem[ix] = (ref_mem[ix] & keep) | (d & ~keep);
      end
      m_cq_c.delete(0);
      m_cq_i.delete(0);
    end
  endfunction

  function automatic void model_reset();
    m_cq_c.delete();
    m_cq_i.delete();
    m_dq_d.delete();
    m_dq_m.delete();
    expq.delete();
    for (int i = 0; i < WRDS; i++) ref_mem[i] = '0;
  endfunction

  // Monitor: every read return is checked against the scoreboard.
  always @(negedge ui_clk) begin
    if (app_rd_data_valid) begin
      n_rx++;
      last_rx_cyc = cyc;
      last_rx = app_rd_data;
      chk("rd_end", app_rd_data_end, 1);
      if (expq.size() == 0) chk("unexpected_rd_valid", app_rd_data_valid, 0);
      else chk("rd_data", app_rd_data, expq.pop_front());
    end else if (app_rd_data_end) begin
      chk("rd_end_idle", app_rd_data_end, 0);
    end
  end

  task automatic step();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] c, input logic [AW-1:0] a);
    bit got = 0;
    app_en = 1'b1;
    app_cmd = c;
    app_addr = a;
    for (int k = 0; k < 300; k++) begin
      @(negedge ui_clk);
      got = app_rdy;
      if (got) last_acc_cyc = cyc;
      if (log_rdy) rdy_log.push_back(got);
      @(posedge ui_clk);
      #1;
      if (got) break;
    end
    app_en = 1'b0;
    if (!got) begin
      chk("cmd_accept_timeout", {255'b0, got}, 1);
    end else begin
      m_cq_c.push_back(c);
      m_cq_i.push_back(int'((a >> 3) % WRDS));
      model_advance();
    end
  endtask

  task automatic send_data(input logic [DW-1:0] d, input logic [MW-1:0] m);
    bit got = 0;
    app_wdf_wren = 1'b1;
    app_wdf_end = 1'b1;
    app_wdf_data = d;
    app_wdf_mask = m;
    for (int k = 0; k < 300; k++) begin
      @(negedge ui_clk);
      got = app_wdf_rdy;
      @(posedge ui_clk);
      #1;
      if (got) break;
    end
    app_wdf_wren = 1'b0;
    app_wdf_end = 1'b0;
    if (!got) begin
      chk("data_accept_timeout", {255'b0, got}, 1);
    end else begin
      m_dq_d.push_back(d);
      m_dq_m.push_back(m);
      model_advance();
    end
  endtask

  task automatic wait_drain();
    int k;
    for (k = 0; k < 2000; k++) begin
      if (expq.size() == 0 && m_cq_c.size() == 0) break;
      step();
    end
    if (k == 2000) chk("drain_timeout", expq.size() + m_cq_c.size(), 0);
    repeat (3) step();
  endtask

  task automatic wait_calib();
    int n = 0;
    int bad = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      n++;
      if (init_calib_complete) break;
      if (app_rdy || app_wdf_rdy) bad++;
    end
    chk("calib_cycles", n, CAL);
    chk("rdy_before_calib", bad, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_calib"}, init_calib_complete, 0);
    chk({tag, "_rdy"}, app_rdy, 0);
    chk({tag, "_wdf_rdy"}, app_wdf_rdy, 0);
    chk({tag, "_rd_valid"}, app_rd_data_valid, 0);
    chk({tag, "_rd_end"}, app_rd_data_end, 0);
    chk({tag, "_rd_data"}, app_rd_data, 0);
    chk({tag, "_acks"}, {app_ref_ack, app_zq_ack}, 0);
    chk({tag, "_proto_err"}, proto_err, 0);
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam int NR = 60;
  logic [2:0]    rc[NR];
  logic [AW-1:0] ra[NR];
  logic [DW-1:0] rdd[NR];
  logic [MW-1:0] rdm[NR];
  logic [AW-1:0] lead_a[5];
  int nwr;
  int rx0;
  int p;
  int k;

  initial begin
    sys_rst = 1'b0;
    app_addr = '0;
    app_cmd = '0;
    app_en = 1'b0;
    app_wdf_data = '0;
    app_wdf_wren = 1'b0;
    app_wdf_end = 1'b0;
    app_wdf_mask = '0;
    app_ref_req = 1'b0;
    app_zq_req = 1'b0;
    model_reset();

    repeat (3) step();
    check_reset_outputs("reset");
    sys_rst = 1'b1;
    wait_calib();
    chk("proto_err_idle", proto_err, 0);

    app_ref_req = 1'b1;
    step();
    app_ref_req = 1'b0;
    chk("ref_ack", {app_ref_ack, app_zq_ack}, 2'b10);
    step();
    chk("ref_ack_drop", app_ref_ack, 0);
    app_zq_req = 1'b1;
    step();
    app_zq_req = 1'b0;
    chk("zq_ack", {app_ref_ack, app_zq_ack}, 2'b01);
    step();
    chk("zq_ack_drop", app_zq_ack, 0);

    fork
      send_cmd(3'b000, 29'h100);
      send_data(rnd_word(), '0);
    join
    wait_drain();
    rx0 = n_rx;
    send_cmd(3'b001, 29'h100);
    for (k = 0; k < 50 && n_rx == rx0; k++) step();
    chk("latency_seen", n_rx - rx0, 1);
    chk("rd_latency", last_rx_cyc - last_acc_cyc, 1 + RDL);
    wait_drain();

    for (int i = 0; i < 10; i++) begin
      fork
        send_cmd(3'b000, AW'(i * 8));
        send_data(DW'(2 * (i + 1)), '0);
      join
    end
    rx0 = n_rx;
    for (int i = 0; i < 10; i++) send_cmd(3'b001, AW'(i * 8));
    wait_drain();
    chk("burst_count", n_rx - rx0, 10);

    for (int i = 0; i < 4; i++) send_data(rnd_word(), MW'($urandom));
    @(negedge ui_clk);
    chk("wdf_rdy_full", app_wdf_rdy, 0);
    step();
    for (int i = 0; i < 5; i++) lead_a[i] = AW'($urandom);
    fork
      send_data(rnd_word(), '0);
      begin
        repeat (3) begin
          @(negedge ui_clk);
          chk("wdf_rdy_held", app_wdf_rdy, 0);
        end
        step();
        for (int i = 0; i < 5; i++) send_cmd(3'b000, lead_a[i]);
      end
    join
    wait_drain();
    @(negedge ui_clk);
    chk("wdf_rdy_back", app_wdf_rdy, 1);
    step();
    for (int i = 0; i < 5; i++) send_cmd(3'b001, lead_a[i]);
    wait_drain();

    fork
      send_cmd(3'b000, 29'd16);
      send_data('1, '0);
    join
    fork
      send_cmd(3'b000, 29'd16);
      send_data('0, 32'hFFFF_FFFE);
    join
    send_cmd(3'b001, 29'd16);
    wait_drain();
    chk("mask_byte0", last_rx, {{31{8'hFF}}, 8'h00});

    nwr = 0;
    for (int i = 0; i < NR; i++) begin
      k = $urandom_range(0, 9);
      if (k < 4) rc[i] = 3'b000;
      else if (k < 8) rc[i] = 3'b001;
      else rc[i] = 3'($urandom_range(2, 7));
      ra[i] = AW'($urandom);
      if (rc[i] == 3'b000) begin
        rdd[nwr] = rnd_word();
        rdm[nwr] = ($urandom_range(0, 1) == 0) ? '0 : MW'($urandom);
        nwr++;
      end
    end
    fork
      begin
        for (int i = 0; i < NR; i++) begin
          repeat ($urandom_range(0, 2)) step();
          send_cmd(rc[i], ra[i]);
        end
      end
      begin
        for (int j = 0; j < nwr; j++) begin
          repeat ($urandom_range(0, 2)) step();
          send_data(rdd[j], rdm[j]);
        end
      end
    join
    wait_drain();

    rdy_log.delete();
    log_rdy = 1;
    rx0 = n_rx;
    for (int i = 0; i < 20; i++) send_cmd(3'b001, AW'($urandom));
    log_rdy = 0;
    wait_drain();
    chk("stall_count", n_rx - rx0, 20);
    p = -1;
    foreach (rdy_log[i]) if (p < 0 && !rdy_log[i]) p = i;
    chk("stall_first_low", (p >= 0 && p < SPER), 1);
    if (p >= 0) begin
      for (int i = p; i < rdy_log.size(); i++) begin
        chk("stall_pattern", rdy_log[i], ((i - p) % SPER) != 0);
      end
    end

    for (int i = 0; i < 3; i++) send_cmd(3'b001, AW'($urandom));
    sys_rst = 1'b0;
    model_reset();
    rx0 = n_rx;
    repeat (3) step();
    check_reset_outputs("midrst");
    sys_rst = 1'b1;
    wait_calib();
    repeat (10) step();
    chk("no_valid_after_reset", n_rx - rx0, 0);
    send_cmd(3'b001, 29'd16);
    wait_drain();
    chk("cleared_word_count", n_rx - rx0, 1);

    chk("proto_err_before", proto_err, 0);
    app_wdf_wren = 1'b1;
    app_wdf_end = 1'b0;
    step();
    app_wdf_wren = 1'b0;
    step();
    chk("proto_err_wren_end", proto_err, 1);

    sys_rst = 1'b0;
    model_reset();
    repeat (2) step();
    check_reset_outputs("rst2");
    sys_rst = 1'b1;
    step();
    app_en = 1'b1;
    app_cmd = 3'b001;
    @(negedge ui_clk);
    chk("rdy_during_calib", app_rdy, 0);
    step();
    app_en = 1'b0;
    step();
    chk("proto_err_en_calib", proto_err, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
